// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// State encoding is exported so checkers can decode the debug state output.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_tt.sv
// One-bit full subtractor as an explicit truth table: a - b - bin -> {bout, d}.
module full_subtractor_tt (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = 1'b0;
        bout = 1'b0;
        case ({a, b, bin})
            3'b000: begin d = 1'b0; bout = 1'b0; end
            3'b001: begin d = 1'b1; bout = 1'b1; end
            3'b010: begin d = 1'b1; bout = 1'b1; end
            3'b011: begin d = 1'b0; bout = 1'b1; end
            3'b100: begin d = 1'b1; bout = 1'b0; end
            3'b101: begin d = 1'b0; bout = 1'b0; end
            3'b110: begin d = 1'b0; bout = 1'b0; end
            3'b111: begin d = 1'b1; bout = 1'b1; end
            default: begin d = 1'b0; bout = 1'b0; end
        endcase
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// Handshake: start is sampled only in IDLE; done pulses one cycle with diff/borrow_out valid.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output state_t           state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] sd;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             bit_d;
    logic             bit_bo;
    logic [WIDTH-1:0] sd_next;

    full_subtractor_tt u_bit (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (borrow),
        .d    (bit_d),
        .bout (bit_bo)
    );

    // New bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH steps.
    assign sd_next   = {bit_d, sd};
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            sa         <= '0;
            sb         <= '0;
            sd         <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    sd     <= sd_next[WIDTH-1:1];
                    borrow <= bit_bo;
                    if (cnt == LAST) begin
                        diff       <= sd_next;
                        borrow_out <= bit_bo;
                        state      <= DONE;
                        done       <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level reference model for WIDTH 8 and 16,
// directed vectors with hand-computed results, and a truth-table sweep of the bit cell.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        chk_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        start8;
    logic [7:0]  a8, b8, diff8;
    logic        busy8, done8, bo8;
    logic [1:0]  st8;

    logic        start16;
    logic [15:0] a16, b16, diff16;
    logic        busy16, done16, bo16;
    logic [1:0]  st16;

    logic        fa, fb, fbin, fd, fbout;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .state_dbg(st8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16), .state_dbg(st16)
    );

    full_subtractor_tt u_fs (.a(fa), .b(fb), .bin(fbin), .d(fd), .bout(fbout));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op is busy for WIDTH+1 cycles, with the result and
    // the done pulse appearing in the last of them; start is only seen when idle.
    int          m8_cnt = 0, m16_cnt = 0;
    logic [7:0]  m8_a = 0, m8_b = 0, m8_diff = 0;
    logic [15:0] m16_a = 0, m16_b = 0, m16_diff = 0;
    logic        m8_bo = 0, m16_bo = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m8_cnt <= 0; m8_diff <= 0; m8_bo <= 0;
        end else if (m8_cnt == 0) begin
            if (start8) begin m8_cnt <= 1; m8_a <= a8; m8_b <= b8; end
        end else if (m8_cnt == 8) begin
            m8_cnt <= 9; m8_diff <= m8_a - m8_b; m8_bo <= (m8_a < m8_b);
        end else if (m8_cnt == 9) begin
            m8_cnt <= 0;
        end else begin
            m8_cnt <= m8_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m16_cnt <= 0; m16_diff <= 0; m16_bo <= 0;
        end else if (m16_cnt == 0) begin
            if (start16) begin m16_cnt <= 1; m16_a <= a16; m16_b <= b16; end
        end else if (m16_cnt == 16) begin
            m16_cnt <= 17; m16_diff <= m16_a - m16_b; m16_bo <= (m16_a < m16_b);
        end else if (m16_cnt == 17) begin
            m16_cnt <= 0;
        end else begin
            m16_cnt <= m16_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy8", 32'(busy8), 32'(m8_cnt != 0));
            check("done8", 32'(done8), 32'(m8_cnt == 9));
            check("diff8", 32'(diff8), 32'(m8_diff));
            check("bo8", 32'(bo8), 32'(m8_bo));
            check("busy16", 32'(busy16), 32'(m16_cnt != 0));
            check("done16", 32'(done16), 32'(m16_cnt == 17));
            check("diff16", 32'(diff16), 32'(m16_diff));
            check("bo16", 32'(bo16), 32'(m16_bo));
        end
    end

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [7:0] ed, input logic eb, input string nm);
        int lat;
        lat = -1;
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb_v;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin lat = i; break; end
        end
        if (lat < 0) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({nm, "_lat"}, 32'(lat), 32'd7);
            check({nm, "_diff"}, 32'(diff8), 32'(ed));
            check({nm, "_bo"}, 32'(bo8), 32'(eb));
            check({nm, "_model"}, 32'(m8_diff), 32'(ed));
        end
    endtask

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] ed, input logic eb, input string nm);
        int lat;
        lat = -1;
        @(negedge clk);
        start16 = 1'b1; a16 = ta; b16 = tb_v;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done16 === 1'b1) begin lat = i; break; end
        end
        if (lat < 0) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({nm, "_lat"}, 32'(lat), 32'd15);
            check({nm, "_diff"}, 32'(diff16), 32'(ed));
            check({nm, "_bo"}, 32'(bo16), 32'(eb));
        end
    endtask

    initial begin
        int dones;
        logic [7:0]  ra8, rb8;
        logic [15:0] ra16, rb16;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        fa = 1'b0; fb = 1'b0; fbin = 1'b0;

        for (int r = 0; r < 8; r++) begin
            {fa, fb, fbin} = 3'(r);
            #1;
            check("fs_d", 32'(fd), 32'(fa ^ fb ^ fbin));
            check("fs_bout", 32'(fbout), 32'((~fa & fb) | (~(fa ^ fb) & fbin)));
        end

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_bo", 32'(bo8), 32'd0);
        chk_en = 1'b1;
        rst_n = 1'b1;

        op8(8'd10, 8'd3, 8'd7, 1'b0, "10m3");
        op8(8'd3, 8'd10, 8'hF9, 1'b1, "3m10");
        repeat (20) @(negedge clk);
        check("hold_diff", 32'(diff8), 32'hF9);
        check("hold_bo", 32'(bo8), 32'd1);

        op8(8'd0, 8'd0, 8'h00, 1'b0, "0m0");
        op8(8'd0, 8'd1, 8'hFF, 1'b1, "0m1");
        op8(8'd255, 8'd255, 8'h00, 1'b0, "255m255");
        op8(8'd255, 8'd0, 8'hFF, 1'b0, "255m0");

        // start held high; operands change while the first op is running
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 3) begin a8 = 8'd1; b8 = 8'd2; end
            if (done8 === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    check("held1_diff", 32'(diff8), 32'd100);
                    check("held1_bo", 32'(bo8), 32'd0);
                end else if (dones == 2) begin
                    check("held2_diff", 32'(diff8), 32'hFF);
                    check("held2_bo", 32'(bo8), 32'd1);
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        check("held_dones", 32'(dones), 32'd2);

        // reset for one edge in the middle of an operation
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd77; b8 = 8'd5;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_bo", 32'(bo8), 32'd0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) dones++;
        end
        check("abort_nodone", 32'(dones), 32'd0);
        op8(8'd50, 8'd20, 8'd30, 1'b0, "50m20");

        op16(16'd1000, 16'd1, 16'd999, 1'b0, "w16_a");
        op16(16'd1, 16'd2, 16'hFFFF, 1'b1, "w16_b");

        for (int n = 0; n < 1000; n++) begin
            ra8 = 8'($urandom_range(0, 255));
            rb8 = 8'($urandom_range(0, 255));
            op8(ra8, rb8, 8'(ra8 - rb8), ra8 < rb8, "rnd8");
        end
        for (int n = 0; n < 1000; n++) begin
            ra16 = 16'($urandom_range(0, 65535));
            rb16 = 16'($urandom_range(0, 65535));
            op16(ra16, rb16, 16'(ra16 - rb16), ra16 < rb16, "rnd16");
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
